// File: rtl/beepboop_pkg.sv
// Shared types and constants for the beepboop serial byte receiver.
package beepboop_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] TERMINATOR         = 8'h00;
    localparam int         DEFAULT_FIFO_DEPTH = 32;

endpackage

// File: rtl/beepboop_fifo.sv
// First-word-fall-through byte buffer; a push into a full buffer is accepted only alongside a pop.
module beepboop_fifo
    import beepboop_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = empty ? 8'h00 : mem[rd_ptr];

    // Storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/beepboop_rx.sv
// Serial MSB-first byte receiver with a null-terminated frame protocol and a byte buffer.
// Define BEEPBOOP_RX_CHECKSUM_EN to keep a running XOR checksum of each frame on chk.
module beepboop_rx
    import beepboop_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ser_in,
    input  logic       ser_valid,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       msg_done,
    output logic       frame_err,
    output logic       overflow,
    output logic [7:0] chk
);

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic [7:0] next_byte;
    logic       byte_done;
    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;

    always_comb begin
        next_byte = {shift_reg[6:0], ser_in};
        byte_done = (state == RECV) && ser_valid && (bit_cnt == 3'd7);
        push      = byte_done && (next_byte != TERMINATOR);
    end

    assign pop      = rd_en && !fifo_empty;
    assign rd_valid = !fifo_empty;
    assign busy     = (state == RECV);

    beepboop_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_data(next_byte),
        .pop      (pop),
        .head_data(rd_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // The bit counter wraps 7 -> 0 on its own, so consecutive bytes need no explicit restart.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            msg_done  <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            msg_done  <= 1'b0;
            frame_err <= 1'b0;
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (ser_valid) begin
                        shift_reg <= {7'b0, ser_in};
                        bit_cnt   <= 3'd1;
                        state     <= RECV;
                    end
                end
                RECV: begin
                    if (ser_valid) begin
                        shift_reg <= next_byte;
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (byte_done && (next_byte == TERMINATOR)) begin
                            msg_done <= 1'b1;
                            state    <= DONE;
                        end
                    end else begin
                        frame_err <= 1'b1;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                        state     <= IDLE;
                    end
                end
                DONE: begin
                    if (!ser_valid) begin
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BEEPBOOP_RX_CHECKSUM_EN
    logic [7:0] chk_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            chk_reg <= 8'h00;
        end else if ((state == IDLE) && ser_valid) begin
            chk_reg <= 8'h00;
        end else if (push) begin
            chk_reg <= chk_reg ^ next_byte;
        end
    end

    assign chk = chk_reg;
`else
    assign chk = 8'h00;
`endif

endmodule
